// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU core and its memory port arbiter.
// Holds the cpustate encodings, the arbiter FSM state codes and the legal
// read-latency range of the program/data RAM.
package cpu_pkg;

    // Front-panel / CPU operating mode
    localparam logic [1:0] ST_STOP  = 2'b00;
    localparam logic [1:0] ST_IN    = 2'b01;
    localparam logic [1:0] ST_CHECK = 2'b10;
    localparam logic [1:0] ST_RUN   = 2'b11;

    // Memory port arbiter FSM states
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT_RD = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_PNL_REL = 3'd4;

    // Legal RAM read latency; the inline wait counter is 2 bits wide
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port RAM owner shared by the CPU datapath and the front-panel loader.
// Latency: write 2 cycles request->done/ack, read 2+RD_LAT cycles.
// Backpressure: CPU is held by combinational cpu_stall until cpu_done; panel
//   gets one access per pnl_req assertion and must drop pnl_req to re-arm.
// Ports: clk/rst (async active-low), cpustate selects the owner, cpu_* is the
//   CPU requester, pnl_* the panel requester, mem_* the RAM side, err sticky.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    cpustate,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    output logic          cpu_done,
    input  logic          pnl_req,
    input  logic          pnl_we,
    input  logic [AW-1:0] pnl_addr,
    input  logic [DW-1:0] pnl_wdata,
    output logic [DW-1:0] pnl_rdata,
    output logic          pnl_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,
    output logic          err
);

    if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_rd_lat_range
        $error("mem_port_arbiter: RD_LAT must be 1..3");
    end

    localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

    logic [2:0] state;
    logic [1:0] lat_cnt;
    logic       own_pnl;   // current access belongs to the panel
    logic       is_rd;     // current access is a real RAM read

    logic       cpu_mode;
    logic       pnl_mode;
    logic       pnl_bad;   // panel direction does not match IN/CHECK mode

    always_comb begin
        cpu_mode = 1'b0;
        pnl_mode = 1'b0;
        pnl_bad  = 1'b0;
        case (cpustate)
            ST_STOP:  ;
            ST_IN:    begin pnl_mode = 1'b1; pnl_bad = ~pnl_we; end
            ST_CHECK: begin pnl_mode = 1'b1; pnl_bad = pnl_we;  end
            ST_RUN:   cpu_mode = 1'b1;
            default:  ;
        endcase
    end

    // Stall covers the cycles a request waits in IDLE as well as the access
    assign cpu_stall = (cpu_read | cpu_write) & ~cpu_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            lat_cnt   <= 2'd0;
            own_pnl   <= 1'b0;
            is_rd     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            cpu_rdata <= '0;
            pnl_rdata <= '0;
            cpu_done  <= 1'b0;
            pnl_ack   <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            mem_re   <= 1'b0;
            cpu_done <= 1'b0;
            pnl_ack  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_mode && (cpu_read || cpu_write)) begin
                        // Read+write together resolves to a write, flagged as an error
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        own_pnl   <= 1'b0;
                        is_rd     <= ~cpu_write;
                        mem_we    <= cpu_write;
                        mem_re    <= ~cpu_write;
                        if (cpu_read && cpu_write) err <= 1'b1;
                        state     <= S_ISSUE;
                    end else if (pnl_mode && pnl_req) begin
                        // A refused panel access still runs the FSM so it gets an ack
                        mem_addr  <= pnl_addr;
                        mem_wdata <= pnl_wdata;
                        own_pnl   <= 1'b1;
                        is_rd     <= ~pnl_we & ~pnl_bad;
                        mem_we    <= pnl_we & ~pnl_bad;
                        mem_re    <= ~pnl_we & ~pnl_bad;
                        if (pnl_bad) err <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (is_rd) begin
                        lat_cnt <= 2'd0;
                        state   <= S_WAIT_RD;
                    end else begin
                        cpu_done <= ~own_pnl;
                        pnl_ack  <= own_pnl;
                        state    <= S_DONE;
                    end
                end
                S_WAIT_RD: begin
                    // Last wait cycle is the RD_LAT-th cycle after mem_re
                    if (lat_cnt == LAST_WAIT) begin
                        if (own_pnl) pnl_rdata <= mem_rdata;
                        else         cpu_rdata <= mem_rdata;
                        cpu_done <= ~own_pnl;
                        pnl_ack  <= own_pnl;
                        state    <= S_DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                S_DONE: begin
                    state <= own_pnl ? S_PNL_REL : S_IDLE;
                end
                S_PNL_REL: begin
                    if (!pnl_req) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import cpu_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    cpustate;
    logic          cpu_read, cpu_write;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall, cpu_done;
    logic          pnl_req, pnl_we;
    logic [AW-1:0] pnl_addr;
    logic [DW-1:0] pnl_wdata, pnl_rdata;
    logic          pnl_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we, mem_re, err;

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .cpustate(cpustate),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .cpu_done(cpu_done), .pnl_req(pnl_req), .pnl_we(pnl_we),
        .pnl_addr(pnl_addr), .pnl_wdata(pnl_wdata), .pnl_rdata(pnl_rdata),
        .pnl_ack(pnl_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    // RAM model: RD_LAT=2 read pipeline, 8'hEE when no read is in flight
    logic [7:0] ram [256];
    logic [7:0] rd_s1, rd_s2;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        rd_s1 <= mem_re ? ram[mem_addr] : 8'hEE;
        rd_s2 <= rd_s1;
    end
    assign mem_rdata = rd_s2;

    // Output bundle: we re done stall ack err | cpu_rdata pnl_rdata mem_addr mem_wdata
    function automatic logic [37:0] outs();
        return {mem_we, mem_re, cpu_done, cpu_stall, pnl_ack, err,
                cpu_rdata, pnl_rdata, mem_addr, mem_wdata};
    endfunction

    typedef struct {
        string       name;
        logic [1:0]  st;
        logic        rd, wr;
        logic [7:0]  ca, cd;
        logic        pr, pw;
        logic [7:0]  pa, pd;
        logic [37:0] exp;
    } vec_t;

    vec_t tbl[$];
    int n_vec = 0;
    int n_bad = 0;

    task automatic v(input string name, input logic [1:0] st,
                     input logic rd, input logic wr, input logic [7:0] ca, input logic [7:0] cd,
                     input logic pr, input logic pw, input logic [7:0] pa, input logic [7:0] pd,
                     input logic we, input logic re, input logic dn, input logic stl,
                     input logic ak, input logic er,
                     input logic [7:0] crd, input logic [7:0] prd,
                     input logic [7:0] ma, input logic [7:0] mw);
        vec_t t;
        t.name = name; t.st = st; t.rd = rd; t.wr = wr; t.ca = ca; t.cd = cd;
        t.pr = pr; t.pw = pw; t.pa = pa; t.pd = pd;
        t.exp = {we, re, dn, stl, ak, er, crd, prd, ma, mw};
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        cpustate = t.st; cpu_read = t.rd; cpu_write = t.wr;
        cpu_addr = t.ca; cpu_wdata = t.cd;
        pnl_req = t.pr; pnl_we = t.pw; pnl_addr = t.pa; pnl_wdata = t.pd;
    endtask

    initial begin
        int lat;
        // 1: CPU write 10<=5A
        v("wr_req",    ST_RUN,0,1,8'h10,8'h5A, 0,0,8'h00,8'h00, 0,0,0,1,0,0, 8'h00,8'h00,8'h00,8'h00);
        v("wr_issue",  ST_RUN,0,1,8'h10,8'h5A, 0,0,8'h00,8'h00, 1,0,0,1,0,0, 8'h00,8'h00,8'h10,8'h5A);
        v("wr_done",   ST_RUN,0,1,8'h10,8'h5A, 0,0,8'h00,8'h00, 0,0,1,0,0,0, 8'h00,8'h00,8'h10,8'h5A);
        v("wr_idle",   ST_RUN,0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,0,0, 8'h00,8'h00,8'h10,8'h5A);
        // 2: CPU read 10, RD_LAT=2
        v("rd_req",    ST_RUN,1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0,0,0,1,0,0, 8'h00,8'h00,8'h10,8'h5A);
        v("rd_issue",  ST_RUN,1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0,1,0,1,0,0, 8'h00,8'h00,8'h10,8'h00);
        v("rd_wait0",  ST_RUN,1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0,0,0,1,0,0, 8'h00,8'h00,8'h10,8'h00);
        v("rd_wait1",  ST_RUN,1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0,0,0,1,0,0, 8'h00,8'h00,8'h10,8'h00);
        v("rd_done",   ST_RUN,1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0,0,1,0,0,0, 8'h5A,8'h00,8'h10,8'h00);
        v("rd_idle",   ST_RUN,0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,0,0, 8'h5A,8'h00,8'h10,8'h00);
        // 3: panel write held for 10 cycles, then a second write after re-arm
        v("in_req",    ST_IN,0,0,8'h00,8'h00, 1,1,8'h03,8'hC3, 0,0,0,0,0,0, 8'h5A,8'h00,8'h10,8'h00);
        v("in_issue",  ST_IN,0,0,8'h00,8'h00, 1,1,8'h03,8'hC3, 1,0,0,0,0,0, 8'h5A,8'h00,8'h03,8'hC3);
        v("in_ack",    ST_IN,0,0,8'h00,8'h00, 1,1,8'h03,8'hC3, 0,0,0,0,1,0, 8'h5A,8'h00,8'h03,8'hC3);
        for (int i = 0; i < 7; i++)
            v("in_hold", ST_IN,0,0,8'h00,8'h00, 1,1,8'h03,8'hC3, 0,0,0,0,0,0, 8'h5A,8'h00,8'h03,8'hC3);
        v("in_rel",    ST_IN,0,0,8'h00,8'h00, 0,1,8'h03,8'hC3, 0,0,0,0,0,0, 8'h5A,8'h00,8'h03,8'hC3);
        v("in_req2",   ST_IN,0,0,8'h00,8'h00, 1,1,8'h04,8'h3C, 0,0,0,0,0,0, 8'h5A,8'h00,8'h03,8'hC3);
        v("in_issue2", ST_IN,0,0,8'h00,8'h00, 1,1,8'h04,8'h3C, 1,0,0,0,0,0, 8'h5A,8'h00,8'h04,8'h3C);
        v("in_ack2",   ST_IN,0,0,8'h00,8'h00, 1,1,8'h04,8'h3C, 0,0,0,0,1,0, 8'h5A,8'h00,8'h04,8'h3C);
        v("in_rel2",   ST_IN,0,0,8'h00,8'h00, 0,1,8'h04,8'h3C, 0,0,0,0,0,0, 8'h5A,8'h00,8'h04,8'h3C);
        // 4: panel ignored in RUN; mode switches to CHECK during a CPU read
        v("run_pnl",   ST_RUN,0,0,8'h00,8'h00, 1,0,8'h03,8'h00, 0,0,0,0,0,0, 8'h5A,8'h00,8'h04,8'h3C);
        v("run_pnl2",  ST_RUN,0,0,8'h00,8'h00, 1,0,8'h03,8'h00, 0,0,0,0,0,0, 8'h5A,8'h00,8'h04,8'h3C);
        v("mix_req",   ST_RUN,1,0,8'h04,8'h00, 1,0,8'h03,8'h00, 0,0,0,1,0,0, 8'h5A,8'h00,8'h04,8'h3C);
        v("mix_issue", ST_CHECK,1,0,8'h04,8'h00, 1,0,8'h03,8'h00, 0,1,0,1,0,0, 8'h5A,8'h00,8'h04,8'h00);
        v("mix_wait0", ST_CHECK,1,0,8'h04,8'h00, 1,0,8'h03,8'h00, 0,0,0,1,0,0, 8'h5A,8'h00,8'h04,8'h00);
        v("mix_wait1", ST_CHECK,1,0,8'h04,8'h00, 1,0,8'h03,8'h00, 0,0,0,1,0,0, 8'h5A,8'h00,8'h04,8'h00);
        v("mix_done",  ST_CHECK,1,0,8'h04,8'h00, 1,0,8'h03,8'h00, 0,0,1,0,0,0, 8'h3C,8'h00,8'h04,8'h00);
        v("chk_grant", ST_CHECK,0,0,8'h04,8'h00, 1,0,8'h03,8'h00, 0,0,0,0,0,0, 8'h3C,8'h00,8'h04,8'h00);
        v("chk_issue", ST_CHECK,0,0,8'h04,8'h00, 1,0,8'h03,8'h00, 0,1,0,0,0,0, 8'h3C,8'h00,8'h03,8'h00);
        v("chk_wait0", ST_CHECK,0,0,8'h04,8'h00, 1,0,8'h03,8'h00, 0,0,0,0,0,0, 8'h3C,8'h00,8'h03,8'h00);
        v("chk_wait1", ST_CHECK,0,0,8'h04,8'h00, 1,0,8'h03,8'h00, 0,0,0,0,0,0, 8'h3C,8'h00,8'h03,8'h00);
        v("chk_ack",   ST_CHECK,0,0,8'h04,8'h00, 1,0,8'h03,8'h00, 0,0,0,0,1,0, 8'h3C,8'hC3,8'h03,8'h00);
        v("chk_rel",   ST_CHECK,0,0,8'h00,8'h00, 0,0,8'h03,8'h00, 0,0,0,0,0,0, 8'h3C,8'hC3,8'h03,8'h00);
        // 5: read+write together, then wrong panel direction in CHECK
        v("both_req",  ST_RUN,1,1,8'h20,8'h77, 0,0,8'h00,8'h00, 0,0,0,1,0,0, 8'h3C,8'hC3,8'h03,8'h00);
        v("both_iss",  ST_RUN,1,1,8'h20,8'h77, 0,0,8'h00,8'h00, 1,0,0,1,0,1, 8'h3C,8'hC3,8'h20,8'h77);
        v("both_done", ST_RUN,1,1,8'h20,8'h77, 0,0,8'h00,8'h00, 0,0,1,0,0,1, 8'h3C,8'hC3,8'h20,8'h77);
        v("both_idle", ST_RUN,0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,0,1, 8'h3C,8'hC3,8'h20,8'h77);
        v("bad_req",   ST_CHECK,0,0,8'h00,8'h00, 1,1,8'h05,8'h99, 0,0,0,0,0,1, 8'h3C,8'hC3,8'h20,8'h77);
        v("bad_issue", ST_CHECK,0,0,8'h00,8'h00, 1,1,8'h05,8'h99, 0,0,0,0,0,1, 8'h3C,8'hC3,8'h05,8'h99);
        v("bad_ack",   ST_CHECK,0,0,8'h00,8'h00, 1,1,8'h05,8'h99, 0,0,0,0,1,1, 8'h3C,8'hC3,8'h05,8'h99);
        v("bad_rel",   ST_CHECK,0,0,8'h00,8'h00, 0,1,8'h05,8'h99, 0,0,0,0,0,1, 8'h3C,8'hC3,8'h05,8'h99);
        v("err_stick", ST_STOP,0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,0,1, 8'h3C,8'hC3,8'h05,8'h99);

        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        rd_s1 = 8'hEE;
        rd_s2 = 8'hEE;

        rst = 1'b0;
        cpustate = ST_STOP; cpu_read = 1'b0; cpu_write = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        pnl_req = 1'b0; pnl_we = 1'b0; pnl_addr = '0; pnl_wdata = '0;
        #12;
        check("reset", outs(), 38'h0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            drive(tbl[i]);
            @(negedge clk);
            check(tbl[i].name, outs(), tbl[i].exp);
        end

        // 6: reset in WAIT_RD aborts the read, then a fresh read completes
        @(posedge clk); #1;
        cpustate = ST_RUN; cpu_read = 1'b1; cpu_addr = 8'h20;
        @(posedge clk); #1;   // ISSUE
        @(posedge clk); #1;   // WAIT_RD
        #2;
        rst = 1'b0;
        cpu_read = 1'b0;
        #1;
        check("rst_async", outs(), 38'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_nodone", {37'h0, cpu_done}, 38'h0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        cpu_read = 1'b1; cpu_addr = 8'h20;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cpu_done) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        check("post_rst_lat", 38'(lat), 38'd4);
        check("post_rst_data", {30'h0, cpu_rdata}, {30'h0, 8'h77});
        @(posedge clk); #1;
        cpu_read = 1'b0;
        @(negedge clk);
        check("post_rst_idle", outs(), {6'b000000, 8'h77, 8'h00, 8'h20, 8'h00});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected end before 100000");
        $fatal(1, "timeout");
    end

endmodule
